seg7_scan_ctrl: RTL and testbench
=================================

// Module: seg7_scan_ctrl
// PURPOSE
//  Time-multiplexed scan controller for the board's common-anode 7-segment display bank.
//  Holds a frame of NUM_DIGITS hex nibbles and walks the anodes one digit at a time.
//  Decodes the current nibble with hex_to_7seg and inserts guard dead-time between digits.
//  Applies new data only at frame boundaries, so the processor's debug/output port never shows a torn value.
// PARAMETERS
//  NUM_DIGITS   4      digits scanned; disp_data is 4*NUM_DIGITS bits wide
//  REFRESH_DIV  50000  clk cycles per digit slot; must be > GUARD_CYC+1
//  GUARD_CYC    500    cycles at slot start with all anodes off (anti-ghosting); may be 0
// PORTS
//  clk         in   1             system clock; single clock domain
//  reset       in   1             synchronous, active-high reset
//  disp_data   in   4*NUM_DIGITS  hex value; nibble i -> digit i, digit 0 rightmost
//  dp_in       in   NUM_DIGITS    decimal-point enables, one per digit; captured with disp_data
//  disp_load   in   1             1-cycle strobe: capture disp_data/dp_in into the pending register
//  blank       in   1             1 = all anodes off; scanning continues
//  lz_en       in   1             1 = suppress leading zeros
//  an          out  NUM_DIGITS    anode enables, active-low
//  seg         out  7             {a,b,c,d,e,f,g}, active-low, from hex_to_7seg
//  dp_n        out  1             decimal point, active-low
//  frame_done  out  1             1-cycle pulse on the last cycle of the digit NUM_DIGITS-1 slot
//  disp_ack    out  1             1-cycle pulse the cycle after pending data becomes active
// BEHAVIOUR
//  Reset values: an=all 1, seg=7'h7F, dp_n=1, frame_done=0, disp_ack=0.
//  Reset internal state: slot_cnt=0, dig_idx=0, active=0, pending=0, pend_vld=0, state=GUARD.
//  All outputs are registered. Reset asserted mid-frame returns to these values on the next edge.
//  slot_cnt runs 0..REFRESH_DIV-1 and wraps. On wrap, dig_idx increments mod NUM_DIGITS.
//  FSM, two states:
//   GUARD: an all 1, seg 7'h7F, dp_n=1. Go to DRIVE when slot_cnt==GUARD_CYC-1.
//          If GUARD_CYC==0, GUARD is skipped and the FSM sits in DRIVE.
//   DRIVE: an[dig_idx]=0 and other anodes 1; seg=decode(active nibble dig_idx); dp_n=~dp(dig_idx).
//          Go to GUARD on slot_cnt wrap.
//  Output latency: 1 cycle from slot_cnt/dig_idx to an/seg/dp_n.
//  Load handshake:
//   - disp_load=1 -> pending<=disp_data/dp_in and pend_vld<=1.
//   - A repeated load before the boundary overwrites pending (last wins). No backpressure.
//  Frame boundary: slot_cnt==REFRESH_DIV-1 and dig_idx==NUM_DIGITS-1.
//   - frame_done pulses on this cycle.
//   - If pend_vld: active<=pending, pend_vld<=0, disp_ack pulses next cycle.
//   - disp_load on the boundary cycle: disp_data goes straight to active, pend_vld<=0, disp_ack pulses.
//  Leading-zero suppression (lz_en=1): digit i is blanked if nibbles i..NUM_DIGITS-1 of active are all 0.
//   - Digit 0 is never blanked.
//   - A blanked digit holds its anode high; its dp is still shown if dp bit set.
//  blank=1 forces an=all 1 on the next edge, overriding everything. Counters, FSM and loads are unaffected.
// STRUCTURE
//  Shared package: SEG_OFF=7'h7F, AN_OFF, state encodings GUARD/DRIVE.
//  Sub-module: hex_to_7seg instantiated once on the muxed nibble (output registered here).
//  Counter widths: $clog2(REFRESH_DIV) for slot_cnt, $clog2(NUM_DIGITS) for dig_idx (min 1).
// TESTING (sim params: NUM_DIGITS=4, REFRESH_DIV=8, GUARD_CYC=2)
//  1. Reset, no load -> an=4'hF, seg=7'h7F for 2 cycles. Then an=4'hE, seg=7'h01 (digit 0 shows "0"). Rest of frame all "0".
//  2. Load 16'h12AF with dp_in=4'b0100 mid-frame, then check the next frame:
//     - disp_ack pulses once after frame_done.
//     - Digits 0..3 show seg 7'h38/7'h08/7'h12/7'h4F.
//     - dp_n=0 only while an=4'hB.
//  3. lz_en=1 with active 16'h0030 -> digits 3,2 keep an high in DRIVE. Digit 1 shows 7'h06, digit 0 shows 7'h01.
//  4. Two loads (16'h1111 then 16'h2222) before the boundary -> next frame shows all "2", and disp_ack pulses once.
//  5. Load 16'hBEEF on the boundary cycle -> next cycle active=16'hBEEF, and digit 0 of the new frame shows 7'h38.
//  6. blank=1 mid-DRIVE -> an=4'hF the next cycle. frame_done keeps pulsing every 32 cycles.
//  7. Reset mid-frame -> all outputs return to reset values the next edge.

Source files
------------

// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared constants and FSM encoding for the 7-segment scan controller.
package seg7_scan_ctrl_pkg;

    localparam int unsigned SEG_W      = 7;
    localparam int unsigned MAX_DIGITS = 32;

    localparam logic [SEG_W-1:0]      SEG_OFF = 7'h7F;
    localparam logic [MAX_DIGITS-1:0] AN_OFF  = '1;

    typedef enum logic {
        GUARD = 1'b0,
        DRIVE = 1'b1
    } state_e;

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Display data/load handshake and panel drive signals of the scan controller.
interface seg7_scan_ctrl_if #(
    parameter int unsigned NUM_DIGITS = 4
);

    logic [4*NUM_DIGITS-1:0] disp_data;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    disp_load;
    logic                    blank;
    logic                    lz_en;
    logic [NUM_DIGITS-1:0]   an;
    logic [6:0]              seg;
    logic                    dp_n;
    logic                    frame_done;
    logic                    disp_ack;

    modport master (
        output disp_data, dp_in, disp_load, blank, lz_en,
        input  an, seg, dp_n, frame_done, disp_ack
    );

    modport slave (
        input  disp_data, dp_in, disp_load, blank, lz_en,
        output an, seg, dp_n, frame_done, disp_ack
    );

endinterface

// File: rtl/seg7_scan_ctrl_hex_to_7seg.sv
// Combinational hex nibble to active-low {a,b,c,d,e,f,g} segment decoder.
module hex_to_7seg
    import seg7_scan_ctrl_pkg::*;
(
    input  logic [3:0]       nib,
    output logic [SEG_W-1:0] seg_c
);

    always_comb begin
        seg_c = SEG_OFF;
        unique case (nib)
            4'h0: seg_c = 7'h01;
            4'h1: seg_c = 7'h4F;
            4'h2: seg_c = 7'h12;
            4'h3: seg_c = 7'h06;
            4'h4: seg_c = 7'h4C;
            4'h5: seg_c = 7'h24;
            4'h6: seg_c = 7'h20;
            4'h7: seg_c = 7'h0F;
            4'h8: seg_c = 7'h00;
            4'h9: seg_c = 7'h04;
            4'hA: seg_c = 7'h08;
            4'hB: seg_c = 7'h60;
            4'hC: seg_c = 7'h31;
            4'hD: seg_c = 7'h42;
            4'hE: seg_c = 7'h30;
            4'hF: seg_c = 7'h38;
            default: seg_c = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed common-anode 7-segment scan controller with guard dead-time,
// leading-zero suppression and frame-aligned (tear-free) data updates.
module seg7_scan_ctrl
    import seg7_scan_ctrl_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned GUARD_CYC   = 500
) (
    input  logic             clk,
    input  logic             reset,
    seg7_scan_ctrl_if.slave  bus
);

    localparam int unsigned SLOT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned DIG_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned DATA_W = 4 * NUM_DIGITS;

    localparam logic [SLOT_W-1:0]     SLOT_LAST  = SLOT_W'(REFRESH_DIV - 1);
    localparam logic [SLOT_W-1:0]     SLOT_PRE   = SLOT_W'(REFRESH_DIV - 2);
    localparam logic [SLOT_W-1:0]     GUARD_LAST = SLOT_W'(GUARD_CYC - 1);
    localparam logic [DIG_W-1:0]      DIG_LAST   = DIG_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_ALL_OFF = AN_OFF[NUM_DIGITS-1:0];
    localparam state_e                START_ST   = (GUARD_CYC == 0) ? DRIVE : GUARD;

    logic [SLOT_W-1:0]     slot_cnt;
    logic [DIG_W-1:0]      dig_idx;
    state_e                state;
    logic [DATA_W-1:0]     active;
    logic [DATA_W-1:0]     pending;
    logic [NUM_DIGITS-1:0] dp_act;
    logic [NUM_DIGITS-1:0] dp_pend;
    logic                  pend_vld;

    logic                  slot_wrap_c;
    logic                  boundary_c;
    logic                  pre_boundary_c;
    logic [3:0]            cur_nib_c;
    logic                  cur_dp_c;
    logic                  cur_lz_c;
    logic                  zero_run;
    logic [SEG_W-1:0]      dec_c;
    logic [NUM_DIGITS-1:0] an_sel_c;

    assign slot_wrap_c    = (slot_cnt == SLOT_LAST);
    assign boundary_c     = slot_wrap_c && (dig_idx == DIG_LAST);
    assign pre_boundary_c = (slot_cnt == SLOT_PRE) && (dig_idx == DIG_LAST);
    assign an_sel_c       = ~(NUM_DIGITS'(1) << dig_idx);

    // Select the current digit; walk from the top digit down to track the leading-zero run.
    always_comb begin
        cur_nib_c = 4'h0;
        cur_dp_c  = 1'b0;
        cur_lz_c  = 1'b0;
        zero_run  = 1'b1;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            zero_run = zero_run & (active[4*i +: 4] == 4'h0);
            if (DIG_W'(i) == dig_idx) begin
                cur_nib_c = active[4*i +: 4];
                cur_dp_c  = dp_act[i];
                cur_lz_c  = bus.lz_en & zero_run & (i != 0);
            end
        end
    end

    hex_to_7seg u_dec (
        .nib   (cur_nib_c),
        .seg_c (dec_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_cnt       <= '0;
            dig_idx        <= '0;
            state          <= START_ST;
            active         <= '0;
            pending        <= '0;
            dp_act         <= '0;
            dp_pend        <= '0;
            pend_vld       <= 1'b0;
            bus.an         <= AN_ALL_OFF;
            bus.seg        <= SEG_OFF;
            bus.dp_n       <= 1'b1;
            bus.frame_done <= 1'b0;
            bus.disp_ack   <= 1'b0;
        end else begin
            if (slot_wrap_c) begin
                slot_cnt <= '0;
                dig_idx  <= (dig_idx == DIG_LAST) ? '0 : dig_idx + DIG_W'(1);
            end else begin
                slot_cnt <= slot_cnt + SLOT_W'(1);
            end

            unique case (state)
                GUARD: if (slot_cnt == GUARD_LAST) state <= DRIVE;
                DRIVE: if (slot_wrap_c && (GUARD_CYC != 0)) state <= GUARD;
                default: state <= START_ST;
            endcase

            // Data only switches at the frame boundary; a load on that exact cycle bypasses pending.
            if (boundary_c) begin
                if (bus.disp_load) begin
                    active <= bus.disp_data;
                    dp_act <= bus.dp_in;
                end else if (pend_vld) begin
                    active <= pending;
                    dp_act <= dp_pend;
                end
                pend_vld <= 1'b0;
            end else if (bus.disp_load) begin
                pending  <= bus.disp_data;
                dp_pend  <= bus.dp_in;
                pend_vld <= 1'b1;
            end

            if (state == DRIVE) begin
                bus.an   <= cur_lz_c ? AN_ALL_OFF : an_sel_c;
                bus.seg  <= cur_lz_c ? SEG_OFF : dec_c;
                bus.dp_n <= ~cur_dp_c;
            end else begin
                bus.an   <= AN_ALL_OFF;
                bus.seg  <= SEG_OFF;
                bus.dp_n <= 1'b1;
            end
            if (bus.blank) bus.an <= AN_ALL_OFF;

            // Look one cycle ahead so the registered pulse lands on the boundary cycle itself.
            bus.frame_done <= pre_boundary_c;
            bus.disp_ack   <= boundary_c & (pend_vld | bus.disp_load);
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Randomized + directed bench for seg7_scan_ctrl against a time-indexed frame model.
module tb_seg7_scan_ctrl;

    localparam int unsigned N = 4;
    localparam int unsigned R = 8;
    localparam int unsigned G = 2;
    localparam int unsigned FRAME = N * R;

    logic clk;
    logic reset;

    seg7_scan_ctrl_if #(.NUM_DIGITS(N)) bus ();

    seg7_scan_ctrl #(
        .NUM_DIGITS  (N),
        .REFRESH_DIV (R),
        .GUARD_CYC   (G)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Reference model: elapsed cycles since reset plus the visible and waiting frames.
    int unsigned t = 0;
    logic [15:0] m_act  = '0;
    logic [15:0] m_pend = '0;
    logic [3:0]  m_dp   = '0;
    logic [3:0]  m_dpp  = '0;
    bit          m_pv   = 1'b0;

    logic [6:0] seg_tbl [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
    };

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic tick();
        int unsigned slot;
        int unsigned dig;
        logic [3:0]  e_an;
        logic [6:0]  e_seg;
        logic        e_dp;
        logic        e_fd;
        logic        e_ack;
        logic [3:0]  nib;
        bit          lzb;
        bit          bnd;
        slot = t % R;
        dig  = (t / R) % N;
        bnd  = 1'b0;
        if (reset) begin
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0; e_ack = 1'b0;
        end else begin
            nib = 4'(m_act >> (4 * dig));
            lzb = bus.lz_en && (dig != 0) && ((m_act >> (4 * dig)) == 16'h0);
            if (slot < G) begin
                e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
            end else begin
                e_an  = lzb ? 4'hF : ~(4'(1) << dig);
                e_seg = lzb ? 7'h7F : seg_tbl[nib];
                e_dp  = ~m_dp[dig];
            end
            if (bus.blank) e_an = 4'hF;
            bnd   = (t % FRAME) == FRAME - 1;
            e_ack = bnd && (m_pv || bus.disp_load);
            e_fd  = ((t + 1) % FRAME) == FRAME - 1;
        end

        if (reset) begin
            t = 0; m_act = '0; m_pend = '0; m_dp = '0; m_dpp = '0; m_pv = 1'b0;
        end else begin
            if (bnd) begin
                if (bus.disp_load) begin
                    m_act = bus.disp_data; m_dp = bus.dp_in;
                end else if (m_pv) begin
                    m_act = m_pend; m_dp = m_dpp;
                end
                m_pv = 1'b0;
            end else if (bus.disp_load) begin
                m_pend = bus.disp_data; m_dpp = bus.dp_in; m_pv = 1'b1;
            end
            t++;
        end

        @(posedge clk);
        #1;
        check("an",         32'(bus.an),         32'(e_an));
        check("seg",        32'(bus.seg),        32'(e_seg));
        check("dp_n",       32'(bus.dp_n),       32'(e_dp));
        check("frame_done", 32'(bus.frame_done), 32'(e_fd));
        check("disp_ack",   32'(bus.disp_ack),   32'(e_ack));
        bus.disp_load = 1'b0;
    endtask

    task automatic run(input int unsigned n);
        for (int unsigned k = 0; k < n; k++) tick();
    endtask

    task automatic load(input logic [15:0] d, input logic [3:0] dp);
        bus.disp_data = d;
        bus.dp_in     = dp;
        bus.disp_load = 1'b1;
        tick();
    endtask

    task automatic advance_to(input int unsigned phase);
        for (int unsigned k = 0; k < 2 * FRAME && (t % FRAME) != phase; k++) tick();
    endtask

    initial begin
        reset         = 1'b1;
        bus.disp_data = '0;
        bus.dp_in     = '0;
        bus.disp_load = 1'b0;
        bus.blank     = 1'b0;
        bus.lz_en     = 1'b0;
        run(2);
        reset = 1'b0;

        // Idle after reset: guard, then "0" on every digit.
        run(40);

        // Mid-frame load with a decimal point on digit 2.
        advance_to(10);
        load(16'h12AF, 4'b0100);
        run(70);

        // Leading-zero suppression on 0030.
        bus.lz_en = 1'b1;
        load(16'h0030, 4'b0000);
        run(70);
        bus.lz_en = 1'b0;

        // Last load before the boundary wins.
        advance_to(5);
        load(16'h1111, 4'b0000);
        run(3);
        load(16'h2222, 4'b0000);
        run(70);

        // Load exactly on the boundary cycle.
        advance_to(FRAME - 1);
        load(16'hBEEF, 4'b0001);
        run(40);

        // Blank during DRIVE; scanning and frame pulses continue.
        advance_to(20);
        bus.blank = 1'b1;
        run(70);
        bus.blank = 1'b0;

        // Reset mid-frame.
        advance_to(14);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        run(40);

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            bus.blank = ($urandom % 16) == 0;
            if (($urandom % 64) == 0) bus.lz_en = ~bus.lz_en;
            reset = ($urandom % 700) == 0;
            if (($urandom % 8) == 0) begin
                bus.disp_data = (($urandom % 3) == 0) ? 16'($urandom % 256) : 16'($urandom);
                bus.dp_in     = 4'($urandom);
                bus.disp_load = 1'b1;
            end
            tick();
        end
        reset = 1'b0;
        run(2 * FRAME);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
